// File: rtl/add_serial_param_if.sv
// Operand/result bundle for the parametrised serial adder.
interface add_serial_param_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output en, sub, a, b,
        input  out, cout, ovf, busy, done
    );

    modport slave (
        input  en, sub, a, b,
        output out, cout, ovf, busy, done
    );
endinterface

// File: rtl/add_serial_param.sv
// Bit-serial adder/subtractor: BPC bits per cycle, WIDTH/BPC cycles per result.
//
// state | meaning
// IDLE  | waiting for en, outputs cleared
// ADD   | processing one BPC-bit slice per cycle, busy=1
// DONE  | result stable on out/cout/ovf, en restarts directly
module add_serial_param #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    add_serial_param_if.slave bus
);
    localparam int NCYC = WIDTH / BPC;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    if (WIDTH < 2) begin : g_bad_width
        $error("add_serial_param: WIDTH must be >= 2");
    end
    if ((BPC < 1) || (WIDTH % BPC != 0)) begin : g_bad_bpc
        $error("add_serial_param: BPC must divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]     a_reg, b_reg, out_reg;
    logic [CW-1:0]        count;
    logic                 carry, cout_reg, ovf_reg;
    logic [BPC:0]         slice_sum;
    logic                 carry_in_msb;
    logic                 last;
    logic                 load;
    logic [WIDTH+BPC-1:0] out_cat;

    // Slice add: a carry into the slice MSB is recovered from its sum bit.
    assign slice_sum    = {1'b0, a_reg[BPC-1:0]} + {1'b0, b_reg[BPC-1:0]} + {{BPC{1'b0}}, carry};
    assign carry_in_msb = slice_sum[BPC-1] ^ a_reg[BPC-1] ^ b_reg[BPC-1];
    assign last         = (count == CW'(NCYC - 1));
    assign load         = bus.en && ((state == IDLE) || (state == DONE));
    // Concatenate then drop the low slice so BPC==WIDTH needs no special case.
    assign out_cat      = {slice_sum[BPC-1:0], out_reg};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.en) state_next = ADD;
            ADD:     if (last)   state_next = DONE;
            DONE:    if (bus.en) state_next = ADD;
            default: state_next = IDLE;
        endcase
    end

    // Operand load, slice shifting and final flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            out_reg  <= '0;
            count    <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (load) begin
            a_reg    <= bus.a;
            b_reg    <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.sub;
            count    <= '0;
            out_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (state == ADD) begin
            out_reg <= out_cat[WIDTH+BPC-1:BPC];
            a_reg   <= a_reg >> BPC;
            b_reg   <= b_reg >> BPC;
            carry   <= slice_sum[BPC];
            count   <= count + 1'b1;
            if (last) begin
                cout_reg <= slice_sum[BPC];
                ovf_reg  <= carry_in_msb ^ slice_sum[BPC];
            end
        end
    end

    assign bus.out  = out_reg;
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_reg;
    assign bus.busy = (state == ADD);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_add_serial_param.sv
// Directed bench for add_serial_param in three shapes: 8/1, 16/4 and 8/8.
module tb_add_serial_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    add_serial_param_if #(.WIDTH(8))  if_a ();
    add_serial_param_if #(.WIDTH(16)) if_b ();
    add_serial_param_if #(.WIDTH(8))  if_c ();

    add_serial_param #(.WIDTH(8),  .BPC(1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    add_serial_param #(.WIDTH(16), .BPC(4)) u_b (.clk(clk), .rst(rst), .bus(if_b));
    add_serial_param #(.WIDTH(8),  .BPC(8)) u_c (.clk(clk), .rst(rst), .bus(if_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_a(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic sv,
                         input logic [7:0] eo, input logic ec, input logic eov);
        int n;
        @(negedge clk);
        if_a.en = 1'b1; if_a.a = av; if_a.b = bv; if_a.sub = sv;
        @(negedge clk);
        if_a.en = 1'b0; if_a.a = '0; if_a.b = '0; if_a.sub = 1'b0;
        n = 0;
        while (if_a.busy && n < 50) begin n++; @(negedge clk); end
        chk({tag, "_cycles"}, n, 8);
        chk({tag, "_done"}, if_a.done, 1);
        chk({tag, "_out"}, if_a.out, eo);
        chk({tag, "_cout"}, if_a.cout, ec);
        chk({tag, "_ovf"}, if_a.ovf, eov);
    endtask

    task automatic run_b(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic sv,
                         input logic [15:0] eo, input logic ec, input logic eov);
        int n;
        @(negedge clk);
        if_b.en = 1'b1; if_b.a = av; if_b.b = bv; if_b.sub = sv;
        @(negedge clk);
        if_b.en = 1'b0;
        n = 0;
        while (if_b.busy && n < 50) begin n++; @(negedge clk); end
        chk({tag, "_cycles"}, n, 4);
        chk({tag, "_done"}, if_b.done, 1);
        chk({tag, "_out"}, if_b.out, eo);
        chk({tag, "_cout"}, if_b.cout, ec);
        chk({tag, "_ovf"}, if_b.ovf, eov);
    endtask

    task automatic run_c(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic sv,
                         input logic [7:0] eo, input logic ec, input logic eov);
        int n;
        @(negedge clk);
        if_c.en = 1'b1; if_c.a = av; if_c.b = bv; if_c.sub = sv;
        @(negedge clk);
        if_c.en = 1'b0;
        n = 0;
        while (if_c.busy && n < 50) begin n++; @(negedge clk); end
        chk({tag, "_cycles"}, n, 1);
        chk({tag, "_done"}, if_c.done, 1);
        chk({tag, "_out"}, if_c.out, eo);
        chk({tag, "_cout"}, if_c.cout, ec);
        chk({tag, "_ovf"}, if_c.ovf, eov);
    endtask

    initial begin
        int n;
        if_a.en = 0; if_a.sub = 0; if_a.a = '0; if_a.b = '0;
        if_b.en = 0; if_b.sub = 0; if_b.a = '0; if_b.b = '0;
        if_c.en = 0; if_c.sub = 0; if_c.a = '0; if_c.b = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", if_a.busy, 0);
        chk("rst_done", if_a.done, 0);
        chk("rst_out",  if_a.out, 0);
        chk("rst_cout", if_a.cout, 0);
        chk("rst_ovf",  if_a.ovf, 0);
        rst = 1'b0;

        run_a("add_3c_05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
        run_a("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_a("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_a("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_a("sub_00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
        run_a("sub_05_05", 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0);

        // Inputs wiggling during ADD must not disturb 0x12+0x34.
        @(negedge clk);
        if_a.en = 1'b1; if_a.a = 8'h12; if_a.b = 8'h34; if_a.sub = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            chk("ign_busy", if_a.busy, 1);
            if_a.en  = ~if_a.en;
            if_a.a   = 8'hF0 ^ 8'(i);
            if_a.b   = 8'h0F + 8'(i);
            if_a.sub = ~if_a.sub;
            @(negedge clk);
        end
        if_a.en = 1'b0; if_a.sub = 1'b0;
        @(negedge clk);
        chk("ign_done", if_a.done, 1);
        chk("ign_out",  if_a.out, 8'h46);

        // Restart straight from DONE.
        if_a.en = 1'b1; if_a.a = 8'h10; if_a.b = 8'h20;
        @(negedge clk);
        if_a.en = 1'b0;
        n = 0;
        while (!if_a.done && n < 50) begin n++; @(negedge clk); end
        chk("b2b_done_low", n, 8);
        chk("b2b_out", if_a.out, 8'h30);
        repeat (3) @(negedge clk);
        chk("hold_done", if_a.done, 1);
        chk("hold_out",  if_a.out, 8'h30);

        // Reset in the middle of ADD cycle 4.
        if_a.en = 1'b1; if_a.a = 8'hAA; if_a.b = 8'h11;
        @(negedge clk);
        if_a.en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", if_a.busy, 0);
        chk("mid_rst_done", if_a.done, 0);
        chk("mid_rst_out",  if_a.out, 0);
        chk("mid_rst_cout", if_a.cout, 0);
        chk("mid_rst_ovf",  if_a.ovf, 0);
        rst = 1'b0;
        run_a("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        run_b("w16_ffff_1",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_b("w16_7fff_1",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_b("w16_sub",     16'h1234, 16'h0235, 1'b1, 16'h0FFF, 1'b1, 1'b0);

        run_c("w8b8_add", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
        run_c("w8b8_sub", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
